fe_addsub_pipe: RTL

Combined modular adder/subtractor responder for Fp elements, serving the add/sub request streams that point-arithmetic initiators (e.g. `ec_fpn_dbl`, `ec_fe2_mul_s`) issue through `resource_share`. Accepts one tagged request per cycle and returns `(a ± b) mod P` with the control field echoed, so arbiter routing bits survive the round trip. It is a two-stage valid/ready pipeline with full backpressure and sits directly on the shared-resource side of the arbiter.

---
 rtl/fe_addsub_pipe_pkg.sv | 22 ++
 rtl/if_axi_stream.sv | 27 ++
 rtl/fe_addsub_stage.sv | 70 +++++++
 rtl/fe_addsub_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fe_addsub_pipe_pkg.sv
// ----------------------------------------------------------------------------
// fe_addsub_pipe_pkg
// Shared types and constants for the Fp modular adder/subtractor pipeline.
//   fe_t        : one bn128 base-field element (256 bits)
//   BN128_P     : bn128 base-field prime
//   addsub_op_t : operation selector carried in ctl[OP_BIT]
// ----------------------------------------------------------------------------
package fe_addsub_pipe_pkg;

    localparam int FE_BITS = 256;

    typedef logic [FE_BITS-1:0] fe_t;

    localparam fe_t BN128_P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef enum logic {
        ADDSUB_ADD = 1'b0,
        ADDSUB_SUB = 1'b1
    } addsub_op_t;

endpackage

// File: rtl/if_axi_stream.sv
// ----------------------------------------------------------------------------
// if_axi_stream
// Generic valid/ready stream bundle used between initiators, the arbiter and
// shared arithmetic responders.
//   val/rdy : handshake
//   dat     : payload, DAT_BITS wide
//   ctl     : sideband tag, passed through by responders
//   sop/eop : packet delimiters, mod : empty-byte count of the last beat
//   err     : error flag
// ----------------------------------------------------------------------------
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = ((DAT_BITS / 8) > 1) ? $clog2(DAT_BITS / 8) : 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport sink   (input  val, sop, eop, err, dat, ctl, mod, output rdy);
    modport source (output val, sop, eop, err, dat, ctl, mod, input  rdy);
endinterface

// File: rtl/fe_addsub_stage.sv
// ----------------------------------------------------------------------------
// fe_addsub_stage
// One valid/ready pipeline register carrying {dat, ctl, op, err}.
// The stage loads whenever it is empty or its content is leaving downstream,
// so a full pipeline still moves one beat per cycle. While stalled the held
// payload does not change.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   up_val/up_rdy     : upstream handshake, up_dat/up_ctl/up_op/up_err payload
//   dn_val/dn_rdy     : downstream handshake, dn_dat/dn_ctl/dn_op/dn_err payload
// ----------------------------------------------------------------------------
module fe_addsub_stage
    import fe_addsub_pipe_pkg::*;
#(
    parameter int DAT_BITS = 257,
    parameter int CTL_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                up_val,
    output logic                up_rdy,
    input  logic [DAT_BITS-1:0] up_dat,
    input  logic [CTL_BITS-1:0] up_ctl,
    input  addsub_op_t          up_op,
    input  logic                up_err,
    output logic                dn_val,
    input  logic                dn_rdy,
    output logic [DAT_BITS-1:0] dn_dat,
    output logic [CTL_BITS-1:0] dn_ctl,
    output addsub_op_t          dn_op,
    output logic                dn_err
);

    logic                val_r;
    logic [DAT_BITS-1:0] dat_r;
    logic [CTL_BITS-1:0] ctl_r;
    addsub_op_t          op_r;
    logic                err_r;
    logic                load_s;

    assign load_s = !val_r || dn_rdy;
    assign up_rdy = load_s;

    // Pipeline register: payload only captured for a valid beat so an
    // empty stage keeps its last (or reset) contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val_r <= 1'b0;
            dat_r <= {DAT_BITS{1'b0}};
            ctl_r <= {CTL_BITS{1'b0}};
            op_r  <= ADDSUB_ADD;
            err_r <= 1'b0;
        end else if (load_s) begin
            val_r <= up_val;
            if (up_val) begin
                dat_r <= up_dat;
                ctl_r <= up_ctl;
                op_r  <= up_op;
                err_r <= up_err;
            end
        end
    end

    assign dn_val = val_r;
    assign dn_dat = dat_r;
    assign dn_ctl = ctl_r;
    assign dn_op  = op_r;
    assign dn_err = err_r;

endmodule

// File: rtl/fe_addsub_pipe.sv
// ----------------------------------------------------------------------------
// fe_addsub_pipe
// Two-stage modular adder/subtractor responder for Fp elements.
// Returns (a + b) mod P or (a - b) mod P with ctl echoed bit-exact.
//   Stage 1 registers the raw BITS+1 sum/difference (borrow in the MSB).
//   Stage 2 registers the corrected BITS-wide result.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_addsub_if   : request stream, dat = {b, a}, ctl[OP_BIT] 0=add 1=sub
//   o_addsub_if   : result stream, sop=eop=1, mod=0, err = operand >= P
//   o_req_cnt     : accepted request count
//   o_stall_cnt   : cycles with o_val && !o_rdy
// Build option: FE_ADDSUB_STATS_EN enables the two counters; without it
// both count outputs are tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module fe_addsub_pipe
    import fe_addsub_pipe_pkg::*;
#(
    parameter int              BITS     = 256,
    parameter logic [BITS-1:0] P        = BITS'(BN128_P),
    parameter int              CTL_BITS = 8,
    parameter int              OP_BIT   = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    if_axi_stream.sink    i_addsub_if,
    if_axi_stream.source  o_addsub_if,
    output logic [31:0]   o_req_cnt,
    output logic [31:0]   o_stall_cnt
);

    logic [BITS-1:0]     a_s;
    logic [BITS-1:0]     b_s;
    addsub_op_t          op_in_s;
    logic [BITS:0]       raw_s;
    logic                err_in_s;

    logic                s1_val_s;
    logic [BITS:0]       s1_raw_s;
    logic [CTL_BITS-1:0] s1_ctl_s;
    addsub_op_t          s1_op_s;
    logic                s1_err_s;
    logic                s2_up_rdy_s;
    logic [BITS-1:0]     corr_s;

    logic                s2_val_s;
    logic [BITS-1:0]     s2_dat_s;
    logic [CTL_BITS-1:0] s2_ctl_s;
    addsub_op_t          s2_op_s;
    logic                s2_err_s;
    logic [CTL_BITS-1:0] ctl_out_s;

    assign a_s = i_addsub_if.dat[BITS-1:0];
    assign b_s = i_addsub_if.dat[2*BITS-1:BITS];

    // Raw sum/difference; on subtract the MSB ends up as the borrow.
    always_comb begin
        op_in_s  = addsub_op_t'(i_addsub_if.ctl[OP_BIT]);
        raw_s    = {1'b0, a_s} + {1'b0, b_s};
        err_in_s = (a_s >= P) || (b_s >= P);
        case (op_in_s)
            ADDSUB_ADD: raw_s = {1'b0, a_s} + {1'b0, b_s};
            ADDSUB_SUB: raw_s = {1'b0, a_s} - {1'b0, b_s};
            default:    raw_s = {1'b0, a_s} + {1'b0, b_s};
        endcase
    end

    fe_addsub_stage #(
        .DAT_BITS (BITS + 1),
        .CTL_BITS (CTL_BITS)
    ) u_stage1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .up_val (i_addsub_if.val),
        .up_rdy (i_addsub_if.rdy),
        .up_dat (raw_s),
        .up_ctl (i_addsub_if.ctl),
        .up_op  (op_in_s),
        .up_err (err_in_s),
        .dn_val (s1_val_s),
        .dn_rdy (s2_up_rdy_s),
        .dn_dat (s1_raw_s),
        .dn_ctl (s1_ctl_s),
        .dn_op  (s1_op_s),
        .dn_err (s1_err_s)
    );

    // Single conditional correction. Both corrections are done modulo
    // 2^BITS on the low bits, which equals the full-width result truncated.
    always_comb begin
        corr_s = s1_raw_s[BITS-1:0];
        case (s1_op_s)
            ADDSUB_ADD: begin
                if (s1_raw_s >= {1'b0, P}) begin
                    corr_s = s1_raw_s[BITS-1:0] - P;
                end else begin
                    corr_s = s1_raw_s[BITS-1:0];
                end
            end
            ADDSUB_SUB: begin
                if (s1_raw_s[BITS]) begin
                    corr_s = s1_raw_s[BITS-1:0] + P;
                end else begin
                    corr_s = s1_raw_s[BITS-1:0];
                end
            end
            default: corr_s = s1_raw_s[BITS-1:0];
        endcase
    end

    fe_addsub_stage #(
        .DAT_BITS (BITS),
        .CTL_BITS (CTL_BITS)
    ) u_stage2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .up_val (s1_val_s),
        .up_rdy (s2_up_rdy_s),
        .up_dat (corr_s),
        .up_ctl (s1_ctl_s),
        .up_op  (s1_op_s),
        .up_err (s1_err_s),
        .dn_val (s2_val_s),
        .dn_rdy (o_addsub_if.rdy),
        .dn_dat (s2_dat_s),
        .dn_ctl (s2_ctl_s),
        .dn_op  (s2_op_s),
        .dn_err (s2_err_s)
    );

    // The op bit travels separately through the stages; reinsert it so the
    // echoed ctl carries the operation that was actually performed.
    always_comb begin
        ctl_out_s         = s2_ctl_s;
        ctl_out_s[OP_BIT] = s2_op_s;
    end

    assign o_addsub_if.val = s2_val_s;
    assign o_addsub_if.dat = s2_dat_s;
    assign o_addsub_if.ctl = ctl_out_s;
    assign o_addsub_if.err = s2_err_s;
    assign o_addsub_if.sop = 1'b1;
    assign o_addsub_if.eop = 1'b1;
    assign o_addsub_if.mod = '0;

`ifdef FE_ADDSUB_STATS_EN
    logic [31:0] req_cnt_r;
    logic [31:0] stall_cnt_r;

    // Free-running wrap-around statistics counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_cnt_r   <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (i_addsub_if.val && i_addsub_if.rdy) begin
                req_cnt_r <= req_cnt_r + 32'd1;
            end
            if (s2_val_s && !o_addsub_if.rdy) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign o_req_cnt   = req_cnt_r;
    assign o_stall_cnt = stall_cnt_r;
`else
    assign o_req_cnt   = 32'd0;
    assign o_stall_cnt = 32'd0;
`endif

endmodule
